// File: rtl/usb_tx_pkg.sv
// Shared definitions for the USB transmit line encoder: line states,
// FSM states and protocol constants.
package usb_tx_pkg;

  // Line states encoded as {dp, dm}
  typedef enum logic [1:0] {
    LINE_SE0 = 2'b00,
    LINE_K   = 2'b01,
    LINE_J   = 2'b10
  } line_state_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_EOP_SE0,
    ST_EOP_J
  } tx_state_e;

  localparam logic [7:0] SYNC_BYTE    = 8'h80;
  localparam int         STUFF_LIMIT  = 6;
  localparam int         EOP_SE0_BITS = 2;

endpackage

// File: rtl/usb_nrzi_stuff.sv
// NRZI encoder with bit stuffing. One bit is accepted per adv strobe;
// while a stuff bit is due, stall is high and the offered bit is not consumed.
module usb_nrzi_stuff
  import usb_tx_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic adv,
  input  logic bit_in,
  output logic stall,
  output logic level
);

  logic [2:0] ones_cnt;
  logic       base_level;
  logic [2:0] base_cnt;

  // Clear restarts from J with no ones counted, and may coincide with the first bit
  always_comb begin
    base_level = clear ? 1'b1 : level;
    base_cnt   = clear ? 3'd0 : ones_cnt;
    stall      = (base_cnt == 3'(STUFF_LIMIT));
  end

  // Line level (1 = J) and run length of consecutive ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level    <= 1'b1;
      ones_cnt <= 3'd0;
    end else if (adv) begin
      if (stall || !bit_in) begin
        level    <= ~base_level;
        ones_cnt <= 3'd0;
      end else begin
        level    <= base_level;
        ones_cnt <= base_cnt + 3'd1;
      end
    end else if (clear) begin
      level    <= 1'b1;
      ones_cnt <= 3'd0;
    end
  end

endmodule

// File: rtl/usb_tx_line_enc.sv
// USB transmit line encoder: byte handshake in, SYNC + stuffed NRZI data + EOP
// out on the D+/D- pair. Bit timing divider and packet FSM live here.
module usb_tx_line_enc
  import usb_tx_pkg::*;
#(
  parameter int CLK_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_sop,
  input  logic       in_eop,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       tx_dp,
  output logic       tx_dm,
  output logic       tx_oe,
  output logic       tx_busy,
  output logic       tx_underrun
);

  localparam logic [3:0] DIV_MAX = 4'(CLK_PER_BIT - 1);

  tx_state_e   state, state_next;
  line_state_e line;
  logic [3:0]  div;
  logic        tick;
  logic [3:0]  bit_cnt;
  logic [7:0]  shift_q;
  logic        shift_eop;
  logic [7:0]  hold_data;
  logic        hold_eop;
  logic        hold_full;
  logic        flushing;
  logic        underrun_q;
  logic        hs, sop_hs, load_hold;
  logic        start, adv, enc_bit, move_hold, consume, underrun_now;
  logic        enc_clear, enc_stall, enc_level;

  assign in_ready  = !hold_full;
  assign hs        = in_valid && in_ready;
  assign sop_hs    = hs && !flushing && in_sop;
  assign load_hold = hs && !flushing && !underrun_now &&
                     (in_sop || state == ST_SYNC || state == ST_DATA);
  assign tick      = (state != ST_IDLE) && (div == DIV_MAX);
  assign enc_clear = !(state == ST_SYNC || state == ST_DATA);

  usb_nrzi_stuff u_nrzi (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (enc_clear),
    .adv    (adv),
    .bit_in (enc_bit),
    .stall  (enc_stall),
    .level  (enc_level)
  );

  // Packet state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next state and the bit to feed the encoder at each bit boundary
  always_comb begin
    state_next   = state;
    start        = 1'b0;
    adv          = 1'b0;
    enc_bit      = 1'b0;
    move_hold    = 1'b0;
    consume      = 1'b0;
    underrun_now = 1'b0;
    case (state)
      ST_IDLE: begin
        if (hold_full || sop_hs) begin
          state_next = ST_SYNC;
          start      = 1'b1;
          adv        = 1'b1;
          enc_bit    = SYNC_BYTE[0];
        end
      end
      ST_SYNC: begin
        if (tick) begin
          adv = 1'b1;
          if (bit_cnt == 4'd8) begin
            move_hold  = 1'b1;
            enc_bit    = hold_data[0];
            state_next = ST_DATA;
          end else begin
            consume = 1'b1;
            enc_bit = shift_q[0];
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (enc_stall) begin
            adv = 1'b1;
          end else if (bit_cnt != 4'd8) begin
            adv     = 1'b1;
            consume = 1'b1;
            enc_bit = shift_q[0];
          end else if (shift_eop) begin
            state_next = ST_EOP_SE0;
          end else if (hold_full) begin
            adv       = 1'b1;
            move_hold = 1'b1;
            enc_bit   = hold_data[0];
          end else begin
            underrun_now = 1'b1;
            state_next   = ST_EOP_SE0;
          end
        end
      end
      ST_EOP_SE0: begin
        if (tick && bit_cnt == 4'(EOP_SE0_BITS - 1)) state_next = ST_EOP_J;
      end
      ST_EOP_J: begin
        if (tick) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Bit-time divider, free-running only while a packet is on the line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                div <= 4'd0;
    else if (state == ST_IDLE) div <= 4'd0;
    else if (tick)             div <= 4'd0;
    else                       div <= div + 4'd1;
  end

  // Shift register and bit counter (also counts SE0 bit times during EOP)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q   <= 8'd0;
      shift_eop <= 1'b0;
      bit_cnt   <= 4'd0;
    end else if (start) begin
      shift_q   <= SYNC_BYTE >> 1;
      shift_eop <= 1'b0;
      bit_cnt   <= 4'd1;
    end else if (move_hold) begin
      shift_q   <= hold_data >> 1;
      shift_eop <= hold_eop;
      bit_cnt   <= 4'd1;
    end else if (consume) begin
      shift_q   <= shift_q >> 1;
      bit_cnt   <= bit_cnt + 4'd1;
    end else if (state != state_next) begin
      bit_cnt   <= 4'd0;
    end else if (state == ST_EOP_SE0 && tick) begin
      bit_cnt   <= bit_cnt + 4'd1;
    end
  end

  // One-byte holding register between the handshake and the shifter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_full <= 1'b0;
      hold_data <= 8'd0;
      hold_eop  <= 1'b0;
    end else begin
      if (move_hold) hold_full <= 1'b0;
      if (load_hold) begin
        hold_full <= 1'b1;
        hold_data <= in_data;
        hold_eop  <= in_eop;
      end
    end
  end

  // After starvation, swallow the rest of the packet up to its eop byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flushing   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= underrun_now;
      if (underrun_now)                      flushing <= !(hs && in_eop);
      else if (flushing && hs && in_eop)     flushing <= 1'b0;
    end
  end

  // Line value decoded from the registered state and NRZI level
  always_comb begin
    line = LINE_J;
    case (state)
      ST_SYNC, ST_DATA: line = enc_level ? LINE_J : LINE_K;
      ST_EOP_SE0:       line = LINE_SE0;
      default:          line = LINE_J;
    endcase
  end

  assign {tx_dp, tx_dm} = line;
  assign tx_oe          = (state != ST_IDLE);
  assign tx_busy        = (state != ST_IDLE);
  assign tx_underrun    = underrun_q;

endmodule

// File: tb/tb_usb_tx_line_enc.sv
// Directed bench for usb_tx_line_enc at 4 clocks per bit: records the line
// every cycle the output is enabled and compares against hand-built bit strings.
module tb_usb_tx_line_enc;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_sop = 1'b0;
  logic       in_eop = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_ready, tx_dp, tx_dm, tx_oe, tx_busy, tx_underrun;

  int          check_count = 0;
  int          fail_count  = 0;
  logic [1:0]  line_log[$];
  int          underrun_cnt = 0;
  int          busy_mis = 0;
  logic        first_oe;
  logic [1:0]  first_line;
  logic        ready_after_first;
  int          acc;
  string       sync_s = "KJKJKJKK";

  always #5 clk = ~clk;

  usb_tx_line_enc #(.CLK_PER_BIT(CPB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_sop      (in_sop),
    .in_eop      (in_eop),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .tx_dp       (tx_dp),
    .tx_dm       (tx_dm),
    .tx_oe       (tx_oe),
    .tx_busy     (tx_busy),
    .tx_underrun (tx_underrun)
  );

  // Record line activity mid-cycle
  always @(negedge clk) begin
    if (tx_oe) line_log.push_back({tx_dp, tx_dm});
    if (tx_underrun) underrun_cnt++;
    if (tx_busy !== tx_oe) busy_mis++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [7:0] lineChar(input int idx);
    if (idx >= line_log.size()) return "?";
    case (line_log[idx])
      2'b10:   return "J";
      2'b01:   return "K";
      2'b00:   return "0";
      default: return "X";
    endcase
  endfunction

  task automatic clearLog();
    line_log.delete();
    underrun_cnt = 0;
    busy_mis = 0;
  endtask

  // Present n bytes (byte i in bits [8i+7:8i]) back-to-back on the handshake
  task automatic applyStimulus(input logic [31:0] bytes, input int n, input logic first_sop,
                               input logic last_eop, output int accepted);
    accepted = 0;
    for (int i = 0; i < n; i++) begin
      logic hs;
      hs = 1'b0;
      in_valid = 1'b1;
      in_data  = bytes[8*i +: 8];
      in_sop   = (i == 0) ? first_sop : 1'b0;
      in_eop   = (i == n - 1) ? last_eop : 1'b0;
      for (int t = 0; t < 400 && !hs; t++) begin
        hs = in_ready;
        @(posedge clk);
        #1;
      end
      if (hs) accepted++;
      if (i == 0) begin
        first_oe          = tx_oe;
        first_line        = {tx_dp, tx_dm};
        ready_after_first = in_ready;
      end
    end
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    logic done;
    done = 1'b0;
    for (int n = 0; n < 3000 && !done; n++) begin
      @(negedge clk);
      if (!tx_oe) done = 1'b1;
    end
    checkOutput({tag, "_idle_reached"}, 32'(done), 32'd1);
    checkOutput({tag, "_busy_low_after"}, 32'(tx_busy), 32'd0);
  endtask

  task automatic compareLine(input string name, input string exp);
    logic [7:0]  e;
    logic [31:0] obs;
    checkOutput({name, "_oe_cycles"}, line_log.size(), exp.len() * CPB);
    for (int b = 0; b < exp.len(); b++) begin
      e   = exp[b];
      obs = {lineChar(b*CPB), lineChar(b*CPB+1), lineChar(b*CPB+2), lineChar(b*CPB+3)};
      checkOutput($sformatf("%s_bit%0d", name, b), obs, {e, e, e, e});
    end
  endtask

  task automatic sendAck(input string name);
    clearLog();
    applyStimulus(32'h0000_00D2, 1, 1'b1, 1'b1, acc);
    checkOutput({name, "_accepted"}, acc, 1);
    checkOutput({name, "_first_oe"}, 32'(first_oe), 32'd1);
    checkOutput({name, "_first_line_k"}, 32'(first_line), 32'h1);
    waitIdle(name);
    compareLine(name, {sync_s, "JJKJJKKK00J"});
    checkOutput({name, "_no_underrun"}, underrun_cnt, 0);
    checkOutput({name, "_busy_tracks_oe"}, busy_mis, 0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_oe",       32'(tx_oe),       32'd0);
    checkOutput("rst_dp",       32'(tx_dp),       32'd1);
    checkOutput("rst_dm",       32'(tx_dm),       32'd0);
    checkOutput("rst_busy",     32'(tx_busy),     32'd0);
    checkOutput("rst_underrun", 32'(tx_underrun), 32'd0);
    checkOutput("rst_ready",    32'(in_ready),    32'd1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] ACK 0xD2");
    sendAck("ack");

    $display("[TB] token 0x69 0x00 0x10");
    clearLog();
    applyStimulus(32'h0010_0069, 3, 1'b1, 1'b1, acc);
    checkOutput("tok_accepted", acc, 3);
    checkOutput("tok_ready_low_when_full", 32'(ready_after_first), 32'd0);
    waitIdle("tok");
    compareLine("tok", {sync_s, "KJKKJJJK", "JKJKJKJK", "JKJKKJKJ", "00J"});

    $display("[TB] stuffing 0xFF 0xFF");
    clearLog();
    applyStimulus(32'h0000_FFFF, 2, 1'b1, 1'b1, acc);
    checkOutput("stf_accepted", acc, 2);
    waitIdle("stf");
    compareLine("stf", {sync_s, "KKKKKJJJJJJJKKKKKK", "00J"});

    $display("[TB] trailing stuff 0xFC");
    clearLog();
    applyStimulus(32'h0000_00FC, 1, 1'b1, 1'b1, acc);
    waitIdle("trl");
    compareLine("trl", {sync_s, "JKKKKKKKJ", "00J"});

    $display("[TB] underrun 0xC3");
    clearLog();
    applyStimulus(32'h0000_00C3, 1, 1'b1, 1'b0, acc);
    waitIdle("unr");
    compareLine("unr", {sync_s, "KKJKJKKK", "00J"});
    checkOutput("unr_pulses", underrun_cnt, 1);
    clearLog();
    applyStimulus(32'h0000_00A5, 1, 1'b0, 1'b1, acc);
    checkOutput("flush_accepted", acc, 1);
    repeat (20) @(negedge clk);
    checkOutput("flush_no_line", line_log.size(), 0);
    checkOutput("flush_busy", 32'(tx_busy), 32'd0);
    sendAck("ack_after_flush");

    $display("[TB] stray byte in idle");
    clearLog();
    applyStimulus(32'h0000_0055, 1, 1'b0, 1'b0, acc);
    checkOutput("stray_accepted", acc, 1);
    repeat (20) @(negedge clk);
    checkOutput("stray_no_line", line_log.size(), 0);
    checkOutput("stray_busy", 32'(tx_busy), 32'd0);
    sendAck("ack_after_stray");

    $display("[TB] reset mid-packet");
    clearLog();
    applyStimulus(32'h0000_00D2, 1, 1'b1, 1'b1, acc);
    repeat (41) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_oe",    32'(tx_oe),    32'd0);
    checkOutput("midrst_dp",    32'(tx_dp),    32'd1);
    checkOutput("midrst_dm",    32'(tx_dm),    32'd0);
    checkOutput("midrst_ready", 32'(in_ready), 32'd1);
    checkOutput("midrst_busy",  32'(tx_busy),  32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    sendAck("ack_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
